// File: rtl/isp_mode_ctrl_pkg.sv
// Shared definitions for the ISP display-mode controller: mode codes,
// controller state encoding, mode width and the mode-advance helper.
package isp_pkg;

    localparam int MODE_W = 4;

    localparam logic [MODE_W-1:0] ISP_MODE_RAW = 4'd0;
    localparam logic [MODE_W-1:0] ISP_MODE_CFA = 4'd1;
    localparam logic [MODE_W-1:0] ISP_MODE_AWB = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_SETTLE  = 2'd2
    } isp_state_e;

    // Next mode in the cycle 0..mode_num-1, wrapping back to 0.
    function automatic logic [MODE_W-1:0] isp_next_mode(
        input logic [MODE_W-1:0] mode,
        input logic [MODE_W:0]   mode_num
    );
        if (({1'b0, mode} + 5'd1) >= mode_num) begin
            return {MODE_W{1'b0}};
        end else begin
            return mode + 4'd1;
        end
    endfunction

endpackage

// File: rtl/isp_mode_ctrl_if.sv
// Host mode-change request port (valid/ready). The host drives valid and
// the requested mode; the controller drives ready.
interface isp_mode_ctrl_if;
    import isp_pkg::*;

    logic              req_valid;
    logic [MODE_W-1:0] req_mode;
    logic              req_ready;

    modport master (output req_valid, output req_mode, input  req_ready);
    modport slave  (input  req_valid, input  req_mode, output req_ready);

endinterface

// File: rtl/isp_mode_ctrl_key_debounce.sv
// Push-button conditioning for the mode controller: 2-flop synchronizer,
// saturating stability counter, and a one-cycle press pulse on a debounced
// high-to-low transition. Only instantiated when ISP_MODE_KEY_EN is defined.
module isp_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_key_db;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    logic             w_key_db_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press_nxt;

    // Bring the asynchronous key into the clk domain; idle level is released (1).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new key level only after it has differed from the debounced
    // level for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
    always_comb begin
        w_key_db_nxt = r_key_db;
        w_cnt_nxt    = r_cnt;
        w_press_nxt  = 1'b0;
        if (r_sync2 == r_key_db) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (r_cnt >= (CNT_MAX - CNT_ONE)) begin
            w_key_db_nxt = r_sync2;
            w_cnt_nxt    = {CNT_W{1'b0}};
            w_press_nxt  = r_key_db & ~r_sync2;
        end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    // Debounce state and registered press pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_db <= 1'b1;
            r_cnt    <= {CNT_W{1'b0}};
            r_press  <= 1'b0;
        end else begin
            r_key_db <= w_key_db_nxt;
            r_cnt    <= w_cnt_nxt;
            r_press  <= w_press_nxt;
        end
    end

    assign press = r_press;

endmodule

// File: rtl/isp_mode_ctrl.sv
// Frame-synchronous ISP display-mode controller. Host requests (and, when
// ISP_MODE_KEY_EN is defined, a debounced push-button) select the ISP output
// mux mode; changes take effect only at a vsync rise, and mute covers the
// pipeline-refill frames after each switch.
// Optional feature macro: ISP_MODE_KEY_EN (adds key_n port and debouncer).
module isp_mode_ctrl
    import isp_pkg::*;
#(
    parameter int MODE_NUM        = 3,
    parameter int DEFAULT_MODE    = 1,
    parameter int SETTLE_FRAMES   = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_vsync,
    isp_mode_ctrl_if.slave    req,
    output logic [MODE_W-1:0] isp_disp_mode,
    output logic              mute,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef ISP_MODE_KEY_EN
    ,
    input  logic              key_n
`endif
);

    localparam logic [MODE_W:0]   MODE_NUM_C  = (MODE_W + 1)'(MODE_NUM);
    localparam logic [MODE_W-1:0] DEF_MODE_C  = MODE_W'(DEFAULT_MODE);
    localparam logic [3:0]        SETTLE_C    = 4'(SETTLE_FRAMES);

    // Reject parameter sets the controller cannot honour.
    generate
        if ((MODE_NUM < 1) || (MODE_NUM > 16) || (DEFAULT_MODE >= MODE_NUM) ||
            (SETTLE_FRAMES < 0) || (SETTLE_FRAMES > 15) || (DEBOUNCE_CYCLES < 1)) begin : g_cfg_err
            $error("isp_mode_ctrl: illegal parameter set");
        end
    endgenerate

    isp_state_e        r_state;
    logic              r_vs_d1;
    logic [MODE_W-1:0] r_mode;
    logic [MODE_W-1:0] r_pend_mode;
    logic [3:0]        r_settle_cnt;
    logic              r_mute;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_ready;

    isp_state_e        w_state_nxt;
    logic [MODE_W-1:0] w_mode_nxt;
    logic [MODE_W-1:0] w_pend_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_mute_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_busy_nxt;
    logic              w_ready_nxt;

    logic              w_vs_rise;
    logic              w_xfer;
    logic              w_key_press;
    logic              w_req_fire;
    logic [MODE_W-1:0] w_req_mode;

`ifdef ISP_MODE_KEY_EN
    isp_key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_n),
        .press   (w_key_press)
    );
`else
    assign w_key_press = 1'b0;
`endif

    assign w_vs_rise  = in_vsync & ~r_vs_d1;
    assign w_xfer     = req.req_valid & r_ready;
    // A host transfer in the same cycle takes priority over a key press.
    assign w_req_fire = w_xfer | (w_key_press & r_ready);
    assign w_req_mode = w_xfer ? req.req_mode : isp_next_mode(r_mode, MODE_NUM_C);

    // Delay vsync by one cycle for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_d1 <= 1'b0;
        end else begin
            r_vs_d1 <= in_vsync;
        end
    end

    // Next-state and next-output decode of the mode-switch FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_pend_nxt  = r_pend_mode;
        w_cnt_nxt   = r_settle_cnt;
        w_mute_nxt  = r_mute;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_fire) begin
                    if ({1'b0, w_req_mode} >= MODE_NUM_C) begin
                        w_err_nxt = 1'b1;
                    end else if (w_req_mode == r_mode) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_pend_nxt  = w_req_mode;
                        w_state_nxt = ST_WAIT_VS;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_VS: begin
                if (w_vs_rise) begin
                    w_mode_nxt = r_pend_mode;
                    if (SETTLE_C != 4'd0) begin
                        w_mute_nxt  = 1'b1;
                        w_cnt_nxt   = SETTLE_C;
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_WAIT_VS;
                end
            end
            ST_SETTLE: begin
                if (w_vs_rise) begin
                    // A zero count here can only come from corruption; finish anyway.
                    if (r_settle_cnt <= 4'd1) begin
                        w_cnt_nxt   = 4'd0;
                        w_mute_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_settle_cnt - 4'd1;
                    end
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_mute_nxt  = 1'b0;
                w_cnt_nxt   = 4'd0;
            end
        endcase
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        // Ready stays low through the done/err cycle so a held request is
        // taken only once the completed one has been reported.
        w_ready_nxt = (w_state_nxt == ST_IDLE) & ~w_done_nxt & ~w_err_nxt;
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_mode       <= DEF_MODE_C;
            r_pend_mode  <= {MODE_W{1'b0}};
            r_settle_cnt <= 4'd0;
            r_mute       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_mode       <= w_mode_nxt;
            r_pend_mode  <= w_pend_nxt;
            r_settle_cnt <= w_cnt_nxt;
            r_mute       <= w_mute_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_ready      <= w_ready_nxt;
        end
    end

    assign isp_disp_mode = r_mode;
    assign mute          = r_mute;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign req.req_ready = r_ready;

endmodule

// File: tb/tb_isp_mode_ctrl.sv
// Self-checking bench for isp_mode_ctrl: a table of host requests applied in
// a loop, hand-written multi-cycle sequences, and a scoreboard queue that is
// checked on every done/err pulse.
module tb_isp_mode_ctrl;
    import isp_pkg::*;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       in_vsync = 1'b0;
    logic [3:0] isp_disp_mode;
    logic       mute, busy, done, err;
`ifdef ISP_MODE_KEY_EN
    logic       key_n = 1'b1;
`endif

    isp_mode_ctrl_if u_if ();

    isp_mode_ctrl #(
        .MODE_NUM        (3),
        .DEFAULT_MODE    (1),
        .SETTLE_FRAMES   (2),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_vsync      (in_vsync),
        .req           (u_if),
        .isp_disp_mode (isp_disp_mode),
        .mute          (mute),
        .busy          (busy),
        .done          (done),
        .err           (err)
`ifdef ISP_MODE_KEY_EN
        ,
        .key_n         (key_n)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [3:0] mode;
    } sb_t;

    typedef struct {
        logic [3:0] mode;
        logic       exp_err;
        logic [3:0] exp_mode;
        int         exp_rises;
    } row_t;

    sb_t  sb_q[$];
    row_t rows[8];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic e, input logic [3:0] m);
        sb_t t;
        t.err  = e;
        t.mode = m;
        sb_q.push_back(t);
    endtask

    // Hold valid until ready (bounded), then complete the transfer edge.
    task automatic send(input logic [3:0] m);
        int w;
        u_if.req_valid = 1'b1;
        u_if.req_mode  = m;
        w = 0;
        while (!u_if.req_ready && w < 50) begin
            step();
            w++;
        end
        chk("ready_timeout", int'(w < 50), 1);
        step();
        u_if.req_valid = 1'b0;
    endtask

    // Issue vsync pulses while busy (bounded); returns the number of rises used.
    task automatic run_rises(output int n);
        n = 0;
        while (busy && n < 6) begin
            in_vsync = 1'b1;
            step();
            n++;
            chk("mute_follows_busy", mute, busy);
            in_vsync = 1'b0;
            step();
        end
    endtask

    // Scoreboard: every done/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        sb_t t;
        if (reset_n && (done || err)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected done=%0d err=%0d required=none", done, err);
            end else begin
                t = sb_q.pop_front();
                chk("sb_err", err, t.err);
                chk("sb_mode", isp_disp_mode, t.mode);
            end
        end
    end

    initial begin
        int n;
        rows[0] = '{4'd5,  1'b1, 4'd2, 0};
        rows[1] = '{4'd2,  1'b0, 4'd2, 0};
        rows[2] = '{4'd0,  1'b0, 4'd0, 3};
        rows[3] = '{4'd3,  1'b1, 4'd0, 0};
        rows[4] = '{4'd15, 1'b1, 4'd0, 0};
        rows[5] = '{4'd1,  1'b0, 4'd1, 3};
        rows[6] = '{4'd1,  1'b0, 4'd1, 0};
        rows[7] = '{4'd2,  1'b0, 4'd2, 3};

        u_if.req_valid = 1'b0;
        u_if.req_mode  = 4'd0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Reset state
        chk("rst_mode", isp_disp_mode, 1);
        chk("rst_ready", u_if.req_ready, 1);
        chk("rst_mute", mute, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        // Mode 1 -> 2 with two settle frames, cycle by cycle
        push(1'b0, 4'd2);
        u_if.req_valid = 1'b1;
        u_if.req_mode  = 4'd2;
        step();
        u_if.req_valid = 1'b0;
        chk("t2_busy", busy, 1);
        chk("t2_ready", u_if.req_ready, 0);
        chk("t2_mode_hold", isp_disp_mode, 1);
        step();
        step();
        chk("t2_mode_novs", isp_disp_mode, 1);
        chk("t2_mute_novs", mute, 0);
        in_vsync = 1'b1;
        step();
        chk("t2_mode_sw", isp_disp_mode, 2);
        chk("t2_mute_sw", mute, 1);
        in_vsync = 1'b0;
        step();
        step();
        in_vsync = 1'b1;
        step();
        chk("t2_mute_mid", mute, 1);
        chk("t2_done_mid", done, 0);
        in_vsync = 1'b0;
        step();
        in_vsync = 1'b1;
        step();
        chk("t2_done", done, 1);
        chk("t2_mute_end", mute, 0);
        chk("t2_busy_end", busy, 0);
        chk("t2_ready_done", u_if.req_ready, 0);
        in_vsync = 1'b0;
        step();
        chk("t2_done_pulse", done, 0);
        chk("t2_ready_after", u_if.req_ready, 1);

        // Table of host requests
        for (int i = 0; i < 8; i++) begin
            push(rows[i].exp_err, rows[i].exp_mode);
            send(rows[i].mode);
            chk("row_err", err, rows[i].exp_err);
            chk("row_busy", busy, int'(rows[i].exp_rises > 0));
            chk("row_done", done, int'(!rows[i].exp_err && rows[i].exp_rises == 0));
            run_rises(n);
            chk("row_rises", n, rows[i].exp_rises);
            chk("row_mode", isp_disp_mode, rows[i].exp_mode);
            chk("row_mute", mute, 0);
            step();
            chk("row_ready", u_if.req_ready, 1);
        end

        // Second request held during a switch: taken only after done
        push(1'b0, 4'd0);
        u_if.req_valid = 1'b1;
        u_if.req_mode  = 4'd0;
        step();
        chk("t5_busy", busy, 1);
        u_if.req_mode = 4'd1;
        for (int i = 0; i < 3; i++) begin
            in_vsync = 1'b1;
            step();
            chk("t5_ready_low", u_if.req_ready, 0);
            in_vsync = 1'b0;
            if (i < 2) begin
                step();
                chk("t5_ready_low2", u_if.req_ready, 0);
            end
        end
        chk("t5_done", done, 1);
        chk("t5_busy_end", busy, 0);
        push(1'b0, 4'd1);
        step();
        chk("t5_ready_after", u_if.req_ready, 1);
        step();
        u_if.req_valid = 1'b0;
        chk("t5_second_busy", busy, 1);
        run_rises(n);
        chk("t5_rises", n, 3);
        chk("t5_mode", isp_disp_mode, 1);
        step();

        // Reset during SETTLE
        send(4'd0);
        in_vsync = 1'b1;
        step();
        chk("t6_mode_sw", isp_disp_mode, 0);
        chk("t6_mute_sw", mute, 1);
        in_vsync = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_mode", isp_disp_mode, 1);
        chk("t6_rst_mute", mute, 0);
        chk("t6_rst_busy", busy, 0);
        step();
        reset_n = 1'b1;
        step();
        chk("t6_ready", u_if.req_ready, 1);
        in_vsync = 1'b1;
        step();
        chk("t6_idle_vs_busy", busy, 0);
        chk("t6_idle_vs_mode", isp_disp_mode, 1);
        in_vsync = 1'b0;
        step();

        // vsync rise in the acceptance cycle is not used
        push(1'b0, 4'd2);
        u_if.req_valid = 1'b1;
        u_if.req_mode  = 4'd2;
        in_vsync       = 1'b1;
        step();
        u_if.req_valid = 1'b0;
        chk("t7_mode_acc", isp_disp_mode, 1);
        chk("t7_busy", busy, 1);
        step();
        chk("t7_mode_hold", isp_disp_mode, 1);
        in_vsync = 1'b0;
        step();
        run_rises(n);
        chk("t7_rises", n, 3);
        chk("t7_mode", isp_disp_mode, 2);
        step();

`ifdef ISP_MODE_KEY_EN
        // Debounced key press advances the mode (2 -> 0 with MODE_NUM=3)
        push(1'b0, 4'd0);
        key_n = 1'b0;
        repeat (30) step();
        chk("key_busy", busy, 1);
        key_n = 1'b1;
        run_rises(n);
        chk("key_mode", isp_disp_mode, 0);
        repeat (30) step();
`endif

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
